// File: rtl/sigma_io_responder_if.sv
// CPU-side bus and console TX stream bundle for sigma_io_responder.
interface sigma_io_responder_if;
  logic [15:31] address;
  logic         write_en;
  logic [0:31]  data_in;
  logic [0:31]  data_out;
  logic         hit;
  logic         tx_valid;
  logic [0:7]   tx_data;
  logic         tx_ready;

  modport master (
    output address, write_en, data_in, tx_ready,
    input  data_out, hit, tx_valid, tx_data
  );

  modport slave (
    input  address, write_en, data_in, tx_ready,
    output data_out, hit, tx_valid, tx_data
  );
endinterface

// File: rtl/sigma_io_responder.sv
// Memory-mapped I/O responder: halt mailbox, console TX FIFO, status and cycle counter.
// Optional watchdog auto-halt enabled by defining IO_WATCHDOG_EN.
module sigma_io_responder #(
  parameter logic [15:31] BASE_ADDR  = 17'h00100,
  parameter logic [0:31]  HALT_MAGIC = 32'h00010001,
  parameter int unsigned  FIFO_DEPTH = 8,
  parameter int unsigned  WDOG_LIMIT = 10000
) (
  input  logic              clock,
  input  logic              reset,
  sigma_io_responder_if.slave bus,
  output logic              halted,
  output logic [0:31]       exit_code
);

  localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]  DEPTH_L    = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_HALT   = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CYCLES = 2'd3
  } reg_sel_e;

  reg_sel_e       sel;
  logic           wr_any;
  logic           wr_halt;
  logic           wr_tx;
  logic           wr_status;
  logic           wr_cycles;

  logic [0:7]     mem [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [3:0]     count;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push_ok;
  logic           drop;
  logic           overflow;
  logic [0:31]    cycles;
  logic [0:31]    status;

  assign bus.hit   = (bus.address[15:29] == BASE_ADDR[15:29]);
  assign sel       = reg_sel_e'(bus.address[30:31]);
  assign wr_any    = bus.write_en & bus.hit;
  assign wr_halt   = wr_any & (sel == REG_HALT);
  assign wr_tx     = wr_any & (sel == REG_TXDATA);
  assign wr_status = wr_any & (sel == REG_STATUS);
  assign wr_cycles = wr_any & (sel == REG_CYCLES);

  assign empty   = (count == 4'd0);
  assign full    = (count == DEPTH_L);
  assign pop     = ~empty & bus.tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = wr_tx & (~full | pop);
  assign drop    = wr_tx & ~push_ok;

  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = empty ? '0 : mem[rd_ptr];

  assign status = {halted, overflow, full, empty, 24'd0, count};

  always_comb begin
    bus.data_out = '0;
    if (bus.hit) begin
      case (sel)
        REG_HALT:   bus.data_out = exit_code;
        REG_TXDATA: bus.data_out = '0;
        REG_STATUS: bus.data_out = status;
        REG_CYCLES: bus.data_out = cycles;
        default:    bus.data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.data_in[24:31];
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a W1C write leaves overflow set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (wr_status && bus.data_in[1]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (wr_cycles) begin
      cycles <= bus.data_in;
    end else if (!halted) begin
      cycles <= cycles + 32'd1;
    end
  end

`ifdef IO_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_expire;

  assign wdog_expire = ~halted & ~wr_any & (wdog_cnt == 32'(WDOG_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (wr_any) begin
      wdog_cnt <= '0;
    end else if (!halted) begin
      wdog_cnt <= wdog_cnt + 32'd1;
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_LIMIT == 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted    <= 1'b0;
      exit_code <= '0;
    end else if (!halted) begin
      if (wr_halt) begin
        exit_code <= bus.data_in;
        halted    <= (bus.data_in == HALT_MAGIC);
      end
`ifdef IO_WATCHDOG_EN
      else if (wdog_expire) begin
        halted    <= 1'b1;
        exit_code <= 32'hDEAD0001;
      end
`endif
    end
  end

endmodule
